mem_io_bridge: RTL
==================

Name: mem_io_bridge

Overview:
Parametrised memory/IO access bridge between the CPU load/store stage and the data memory plus memory-mapped IO.
- Decodes each request address into the data-memory or IO region, handles byte/half/word sizes, and sign/zero-extends loads.
- Holds LED output registers and synchronises switch inputs.
- Uses a request/ready handshake so the pipeline stalls across multi-cycle memory latency.
- Replaces the earlier combinational mem/IO mux. Adds multiple IO channels, sub-word access, wait states and error flagging.

Parameters:
- ADDR_W, 32, address width.
- IO_BASE, 32'hFFFF_FC00, first IO address; addresses >= IO_BASE are IO, all others are memory.
- IO_W, 16, width of each LED/switch channel.
- NUM_LED, 2, number of LED channels (1..16).
- NUM_SW, 2, number of switch channels (1..16).
- MEM_LAT, 1, data-memory read latency in cycles (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  access request; held with all request fields until ready.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- load_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, valid when ready.
- ready  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with ready on a faulted access.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables.
- mem_addr  out  ADDR_W  word address (addr with [1:0] cleared).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data, MEM_LAT cycles after mem_en.
- sw_in  in  NUM_SW*IO_W  raw asynchronous switch inputs.
- led_out  out  NUM_LED*IO_W  registered LED outputs.

Behaviour:
- Reset: rst is sampled on the rising clk edge. All outputs and internal state go to 0: rdata, ready, err, mem_en, mem_we, mem_addr, mem_wdata and led_out. The FSM goes to IDLE. An in-flight access is abandoned with no ready.
- Switch synchronisation: sw_in passes through a two-flop synchroniser every cycle, including while in IDLE. IO reads return the synchronised value.
- IO map, offsets from IO_BASE:
  - LED channel k at 0x00+4k, read/write.
  - Switch channel k at 0x40+4k, read-only.
  - Any other IO offset is unmapped.
- Alignment: half accesses require addr[0]=0. Word accesses require addr[1:0]=0. A misaligned access or size=3 is a fault.
- Fault handling: a fault, a store to a switch channel, or an unmapped IO access causes no side effect. The bridge returns ready=1, err=1 and rdata=0 one cycle after acceptance.
- FSM states and transitions:
  - IDLE: req=1 accepts the request and latches it.
    - Memory load: mem_en=1 for one cycle, go to WAIT with counter = MEM_LAT-1.
    - Memory store: mem_en=1 and mem_we=lane mask for one cycle, go to RESP.
    - IO access or fault: go to RESP.
  - WAIT: the counter decrements each cycle. At 0, capture mem_rdata, extract the lane, extend it, go to RESP.
  - RESP: ready=1 (plus err if faulted) for exactly one cycle, then return to IDLE.
- Latency: a memory load takes MEM_LAT+1 cycles from acceptance to ready. Stores, IO accesses and faults take 1 cycle.
- Next request: req may be asserted again in the cycle after ready. No request is accepted while in WAIT or RESP.
- Lane mask for stores: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: mem_wdata replicates the byte or half across all lanes.
- LED writes: the LED channel takes wdata[IO_W-1:0] for word stores. Byte and half stores merge into the addressed lanes of that channel; lanes above IO_W are ignored. The LED register updates on the acceptance edge.
- IO reads: the channel value is zero-padded to 32 bits, then the normal lane extract/extend is applied.
- Load extension: the byte or half is sign-extended when load_unsigned=0 and zero-extended when load_unsigned=1.
- Simultaneous events: rst dominates req. A switch change during an access has no effect on an already-latched read.

Decomposition:
- Package mem_io_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state enum;
  - IO offset constants (LED_OFS=0x00, SW_OFS=0x40);
  - lane-mask function;
  - load extract/extend function.
- One sub-module: io_sync2, a generic two-flop synchroniser with a WIDTH parameter.

Test Plan:
- Reset, then load word from 0x100 with mem_rdata=0x8000_00F1 and MEM_LAT=2 -> ready exactly 3 cycles after acceptance, rdata=0x8000_00F1, err=0.
- Load byte from 0x103, signed, mem_rdata=0x80xx_xxxx -> rdata=0xFFFF_FF80. Same access with load_unsigned=1 -> rdata=0x0000_0080.
- Store half 0xBEEF to 0x102 -> mem_we=4'b1100, mem_wdata=0xBEEF_BEEF, ready 1 cycle after acceptance.
- Store word 0x1234_A5A5 to IO_BASE+0x04 -> led_out[31:16]=0xA5A5, led_out[15:0] unchanged.
- Set sw_in ch1=0x00C3 and wait 2 cycles, then load half unsigned from IO_BASE+0x44 -> rdata=0x0000_00C3.
- Faults, each with no side effects:
  - word load at 0x102 -> err=1, rdata=0, mem_en never asserted;
  - store to IO_BASE+0x40 -> err=1, LED registers unchanged;
  - access to IO_BASE+0x80 -> err=1;
  - rst asserted during WAIT -> no ready pulse, FSM back in IDLE, led_out=0.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the memory/IO bridge: size codes, FSM states,
// IO offsets, store lane masks and load lane extraction.
package mem_io_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned LED_OFS = 32'h00;
    localparam int unsigned SW_OFS  = 32'h40;
    localparam int          CNT_W   = 2;

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] ofs);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << ofs;
            SZ_HALF: m = 4'b0011 << ofs;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_repl(input size_e sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] ofs,
                                                input size_e sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (ofs)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = ofs[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU load/store request/response bundle; master is the pipeline, slave the bridge.
interface mem_io_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              load_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;

    modport master (
        output req, we, size, load_unsigned, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, size, load_unsigned, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/io_sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs.
module io_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mem_io_bridge.sv
// Load/store bridge: decodes data memory vs IO, handles sub-word access,
// LED registers, synchronised switches and multi-cycle memory reads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for req; memory strobe and LED write happen here
// ST_WAIT | memory read in flight, down-counter to capture cycle
// ST_RESP | ready (and err on fault) asserted for one cycle
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'hFFFF_FC00),
    parameter int                IO_W    = 16,
    parameter int                NUM_LED = 2,
    parameter int                NUM_SW  = 2,
    parameter int                MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_io_bridge_if.slave           cpu,
    output logic                     mem_en,
    output logic [3:0]               mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic [NUM_SW*IO_W-1:0]   sw_in,
    output logic [NUM_LED*IO_W-1:0]  led_out
);
    state_e                   state;
    logic [CNT_W-1:0]         cnt;
    logic [31:0]              rdata_q;
    logic                     ready_q;
    logic                     err_q;
    logic [NUM_LED*IO_W-1:0]  led_q;
    logic [NUM_SW*IO_W-1:0]   sw_sync;
    logic [1:0]               lat_ofs;
    size_e                    lat_size;
    logic                     lat_uns;

    size_e             sz;
    logic [ADDR_W-1:0] io_ofs;
    logic [ADDR_W-1:0] led_rel;
    logic [ADDR_W-1:0] sw_rel;
    logic              is_io;
    logic              led_hit;
    logic              sw_hit;
    logic              misalign;
    logic              fault;
    logic              mem_go;
    logic [3:0]        lane;
    logic [31:0]       repl;
    logic [IO_W-1:0]   led_sel;
    logic [IO_W-1:0]   sw_sel;
    logic [IO_W-1:0]   merged;
    logic [31:0]       io_rd32;

    io_sync2 #(.WIDTH(NUM_SW*IO_W)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sw_sync)
    );

    assign sz       = size_e'(cpu.size);
    assign is_io    = cpu.addr >= IO_BASE;
    assign io_ofs   = cpu.addr - IO_BASE;
    // Relative offsets wrap to huge values below each window, so one compare bounds both ends.
    assign led_rel  = io_ofs - ADDR_W'(LED_OFS);
    assign sw_rel   = io_ofs - ADDR_W'(SW_OFS);
    assign led_hit  = is_io && (led_rel < ADDR_W'(4 * NUM_LED));
    assign sw_hit   = is_io && (sw_rel < ADDR_W'(4 * NUM_SW));
    assign misalign = (sz == SZ_ILL)
                   || ((sz == SZ_HALF) && cpu.addr[0])
                   || ((sz == SZ_WORD) && (cpu.addr[1:0] != 2'b00));
    assign fault    = misalign || (is_io && !led_hit && !sw_hit) || (sw_hit && cpu.we);
    assign lane     = lane_mask(sz, cpu.addr[1:0]);
    assign repl     = store_repl(sz, cpu.wdata);
    assign mem_go   = (state == ST_IDLE) && cpu.req && !rst && !is_io && !fault;

    always_comb begin
        led_sel = '0;
        sw_sel  = '0;
        merged  = '0;
        for (int k = 0; k < NUM_LED; k++) begin
            if (led_rel[5:2] == 4'(k)) led_sel = led_q[k*IO_W +: IO_W];
        end
        for (int k = 0; k < NUM_SW; k++) begin
            if (sw_rel[5:2] == 4'(k)) sw_sel = sw_sync[k*IO_W +: IO_W];
        end
        for (int b = 0; b < IO_W; b++) begin
            merged[b] = lane[b/8] ? repl[b] : led_sel[b];
        end
        io_rd32 = led_hit ? 32'(led_sel) : 32'(sw_sel);
    end

    assign mem_en    = mem_go;
    assign mem_we    = (mem_go && cpu.we) ? lane : 4'b0000;
    assign mem_addr  = mem_go ? {cpu.addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = (mem_go && cpu.we) ? repl : 32'h0;
    assign led_out   = led_q;
    assign cpu.rdata = rdata_q;
    assign cpu.ready = ready_q;
    assign cpu.err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            led_q    <= '0;
            lat_ofs  <= '0;
            lat_size <= SZ_BYTE;
            lat_uns  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (cpu.req) begin
                        if (fault) begin
                            state   <= ST_RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (is_io) begin
                            state   <= ST_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= cpu.we ? 32'h0
                                     : load_extend(io_rd32, cpu.addr[1:0], sz, cpu.load_unsigned);
                            if (cpu.we && led_hit) begin
                                for (int k = 0; k < NUM_LED; k++) begin
                                    if (led_rel[5:2] == 4'(k)) led_q[k*IO_W +: IO_W] <= merged;
                                end
                            end
                        end else if (cpu.we) begin
                            state   <= ST_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state    <= ST_WAIT;
                            cnt      <= CNT_W'(MEM_LAT - 1);
                            lat_ofs  <= cpu.addr[1:0];
                            lat_size <= sz;
                            lat_uns  <= cpu.load_unsigned;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rdata_q <= load_extend(mem_rdata, lat_ofs, lat_size, lat_uns);
                        ready_q <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
